tb_status_periph: RTL
=====================

// Module: tb_status_periph
// PURPOSE
//  Memory-mapped status/stdout peripheral on the core data bus inside the tb subsystem.
//  Decodes core stores into the testbench result signals consumed by the top-level checker:
//  tests_passed, tests_failed, exit_valid, exit_value.
//  Buffers printed characters in a FIFO drained by the stdout sink.
//  Exposes a free-running cycle counter for firmware timing.
// PARAMETERS
//  ADDR_BASE   32'h1000_0000  base byte address of the 32-byte register window
//  FIFO_DEPTH  8              stdout FIFO entries (power of 2, >=2)
//  CNT_WIDTH   32             cycle counter width (<=32, zero-extended on read)
// PORTS
//  clk_i          in   1   clock; all logic on rising edge
//  rst_i          in   1   synchronous reset, active-high
//  data_req_i     in   1   bus request
//  data_gnt_o     out  1   grant (combinational, same cycle as req)
//  data_we_i      in   1   1=write, 0=read
//  data_be_i      in   4   byte enables (ignored except PRINT uses wdata[7:0])
//  data_addr_i    in   32  byte address
//  data_wdata_i   in   32  write data
//  data_rvalid_o  out  1   response valid, one cycle after grant
//  data_rdata_o   out  32  read data, valid with rvalid (0 for writes)
//  char_valid_o   out  1   stdout FIFO non-empty
//  char_o         out  8   FIFO head byte
//  char_ready_i   in   1   sink accepts char_o when char_valid_o
//  tests_passed_o out  1   sticky pass flag
//  tests_failed_o out  1   sticky fail flag
//  exit_valid_o   out  1   sticky exit flag
//  exit_value_o   out  32  exit code, held once exit_valid_o set
// BEHAVIOUR
//  Reset (rst_i=1 at edge): all outputs 0, FIFO empty, counter 0; overrides any same-cycle bus op or pop.
//  Hit = data_addr_i[31:5]==ADDR_BASE[31:5]; offset = data_addr_i[4:2]. Requests off-window: never granted.
//  Grant: data_gnt_o = req & hit & ~(we & offset==PRINT & fifo_full). A stalled request holds its inputs.
//  Response: every granted op gives data_rvalid_o=1 on the next cycle, exactly one cycle. Back-to-back grants are allowed.
//  Register map (word offset):
//   0 PRINT  W: push wdata[7:0] into FIFO. R: 0.
//   1 STATUS W: wdata==32'h1 sets tests_passed_o; any other value sets tests_failed_o.
//            First write wins: once either flag is set, further STATUS writes are ignored. R: {30'b0,failed,passed}.
//   2 EXIT   W: if exit_valid_o==0, set exit_valid_o=1 and exit_value_o=wdata; otherwise ignored. R: exit_value_o.
//   3 CYCLES R: zero-extended counter. W: ignored.
//   4 LEVEL  R: FIFO occupancy 0..FIFO_DEPTH. W: ignored.
//   5-7      R: 0. W: ignored (still granted and responded).
//  Flag/exit registers update on the grant edge; visible the cycle after grant.
//  Counter: +1 every non-reset cycle; saturates at all-ones (no wrap).
//  FIFO:
//   - pop when char_valid_o & char_ready_i; push on granted PRINT write.
//   - push+pop same cycle: level unchanged.
//   - push on full is impossible (no grant), even if a pop occurs that cycle.
//   - pop on empty does nothing.
//   - char_o is the oldest byte; pointers wrap modulo FIFO_DEPTH.
//   - char_valid_o=0 and char_o=0 when empty.
// TESTING
//  Reset, then write 0x41,0x42,0x43 to PRINT with char_ready_i=1 -> char_o sequence 'A','B','C'; each rvalid 1 cycle after its gnt.
//  Hold char_ready_i=0 and issue 9 PRINT writes (DEPTH=8) -> 8 grants, LEVEL reads 8, 9th gnt=0; raise ready -> 9th granted next cycle.
//  Write STATUS=1 then STATUS=5 -> tests_passed_o=1 and tests_failed_o=0, STATUS reads 32'h1.
//  Write EXIT=7 then EXIT=0 -> exit_valid_o=1, exit_value_o=7; EXIT reads 7.
//  Read CYCLES twice, 10 cycles apart -> difference 10; CNT_WIDTH=4 run 20 cycles -> reads 15.
//  Assert rst_i mid-stream with FIFO level 5 and exit set -> next cycle all outputs 0, LEVEL reads 0.

Source files
------------

// File: rtl/tb_status_periph.sv
// Memory-mapped status/stdout peripheral: decodes core stores into pass/fail/exit
// result signals, buffers printed bytes in a FIFO and exposes a saturating cycle counter.
module tb_status_periph #(
  parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int             PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    FULL_LEVEL = FIFO_DEPTH[PW:0];
  localparam logic [PW:0]    LEVEL_ONE  = 1;
  localparam logic [PW-1:0]  PTR_ONE    = 1;
  localparam logic [2:0]     OFF_PRINT  = 3'd0;
  localparam logic [2:0]     OFF_STATUS = 3'd1;
  localparam logic [2:0]     OFF_EXIT   = 3'd2;
  localparam logic [2:0]     OFF_CYCLES = 3'd3;
  localparam logic [2:0]     OFF_LEVEL  = 3'd4;

  logic [7:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic [PW:0]          level;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 hit;
  logic [2:0]           offset;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 wr_en;
  logic                 push;
  logic                 pop;
  logic [31:0]          read_data;
  logic                 unused_bits;

  // Byte enables and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{data_be_i, data_addr_i[1:0]};

  assign hit        = data_addr_i[31:5] == ADDR_BASE[31:5];
  assign offset     = data_addr_i[4:2];
  assign fifo_full  = level == FULL_LEVEL;
  assign fifo_empty = level == '0;
  // A PRINT into a full FIFO stalls even if the sink pops this cycle.
  assign data_gnt_o = data_req_i & hit & ~(data_we_i & (offset == OFF_PRINT) & fifo_full);
  assign wr_en      = data_gnt_o & data_we_i;
  assign push       = wr_en & (offset == OFF_PRINT);
  assign pop        = ~fifo_empty & char_ready_i;

  assign char_valid_o = ~fifo_empty;
  assign char_o       = fifo_empty ? 8'h00 : mem[rptr];

  always_comb begin
    read_data = 32'h0;
    case (offset)
      OFF_STATUS: read_data = {30'b0, tests_failed_o, tests_passed_o};
      OFF_EXIT:   read_data = exit_value_o;
      OFF_CYCLES: read_data = 32'(cnt);
      OFF_LEVEL:  read_data = 32'(level);
      default:    read_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= data_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr           <= '0;
      rptr           <= '0;
      level          <= '0;
      cnt            <= '0;
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= 32'h0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= 32'h0;
    end else begin
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= (data_gnt_o & ~data_we_i) ? read_data : 32'h0;
      if (cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + 1'b1;
      // First STATUS write decides the verdict; later ones are ignored.
      if (wr_en && offset == OFF_STATUS && !tests_passed_o && !tests_failed_o) begin
        if (data_wdata_i == 32'h1) tests_passed_o <= 1'b1;
        else                       tests_failed_o <= 1'b1;
      end
      if (wr_en && offset == OFF_EXIT && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= data_wdata_i;
      end
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule
